// File: rtl/id_stage_hazard_pkg.sv
// Shared types and defaults for the decode stage: FSM state, default widths,
// field positions and the packed ID/EX pipeline register.
package id_pkg;

    localparam int ID_DATA_W   = 16;
    localparam int ID_INSTR_W  = 16;
    localparam int ID_PC_W     = 32;
    localparam int ID_N_REGS   = 8;
    localparam int ID_CTRL_W   = 24;
    localparam int ID_SRC1_LSB = 8;
    localparam int ID_SRC2_LSB = 5;

    // Register address width, never narrower than one bit.
    function automatic int addr_width(input int n_regs);
        return (n_regs <= 2) ? 1 : $clog2(n_regs);
    endfunction

    localparam int ID_ADDR_W = addr_width(ID_N_REGS);

    // Decode FSM: S_IMM means an opcode is held waiting for its immediate word.
    typedef enum logic [0:0] {
        S_DECODE = 1'b0,
        S_IMM    = 1'b1
    } id_state_e;

    // ID/EX register contents. Field widths follow the package defaults, so the
    // top-level width parameters must stay at these values.
    typedef struct packed {
        logic                 valid;
        logic [ID_CTRL_W-1:0] ctrl;
        logic [ID_PC_W-1:0]   pc;
        logic [ID_DATA_W-1:0] rd1;
        logic [ID_DATA_W-1:0] rd2;
        logic [ID_DATA_W-1:0] imm;
        logic [ID_ADDR_W-1:0] src1;
        logic [ID_ADDR_W-1:0] src2;
        logic [ID_ADDR_W-1:0] dst;
        logic [3:0]           shamt;
        logic                 reg_write;
        logic                 mem_read;
    } id_ex_t;

endpackage

// File: rtl/id_stage_hazard_regfile_bypass.sv
// N_REGS x DATA_W register file, one write and two combinational read ports.
// A read of the register being written this cycle returns the write data.
module id_regfile_bypass #(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs_reg [N_REGS];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;
    assign rdata1   = rdata[0];
    assign rdata2   = rdata[1];

    // Register storage: cleared on reset, every register writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (int'(waddr) < N_REGS)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            // Read port with write-through bypass; out-of-range addresses read 0.
            always_comb begin
                rdata[gi] = '0;
                if (we && (raddr[gi] == waddr)) begin
                    rdata[gi] = wdata;
                end else if (int'(raddr[gi]) < N_REGS) begin
                    rdata[gi] = regs_reg[raddr[gi]];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage: register read with WB bypass, load-use stall, two-word
// opcode+immediate sequencing and a stallable / flushable ID/EX register.
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int DATA_W   = ID_DATA_W,
    parameter int INSTR_W  = ID_INSTR_W,
    parameter int PC_W     = ID_PC_W,
    parameter int N_REGS   = ID_N_REGS,
    parameter int CTRL_W   = ID_CTRL_W,
    parameter int SRC1_LSB = ID_SRC1_LSB,
    parameter int SRC2_LSB = ID_SRC2_LSB
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_valid,
    input  logic [INSTR_W-1:0]           if_instr,
    input  logic [PC_W-1:0]              if_pc,
    input  logic [CTRL_W-1:0]            dec_ctrl,
    input  logic                         dec_uses_src1,
    input  logic                         dec_uses_src2,
    input  logic                         dec_needs_imm,
    input  logic                         dec_reg_write,
    input  logic                         dec_mem_read,
    input  logic                         flush,
    input  logic                         stall_in,
    output logic                         id_stall,
    input  logic                         wb_we,
    input  logic [addr_width(N_REGS)-1:0] wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         ex_valid,
    output logic [CTRL_W-1:0]            ex_ctrl,
    output logic [PC_W-1:0]              ex_pc,
    output logic [DATA_W-1:0]            ex_rd1,
    output logic [DATA_W-1:0]            ex_rd2,
    output logic [DATA_W-1:0]            ex_imm,
    output logic [addr_width(N_REGS)-1:0] ex_src1,
    output logic [addr_width(N_REGS)-1:0] ex_src2,
    output logic [addr_width(N_REGS)-1:0] ex_dst,
    output logic [3:0]                   ex_shamt,
    output logic                         ex_reg_write,
    output logic                         ex_mem_read
);

    localparam int ADDR_W = addr_width(N_REGS);

    id_state_e state_reg, state_next;
    id_ex_t    ex_reg, ex_next;

    logic [INSTR_W-1:0] hold_instr_reg;
    logic [PC_W-1:0]    hold_pc_reg;
    logic [CTRL_W-1:0]  hold_ctrl_reg;
    logic               hold_uses1_reg, hold_uses2_reg;
    logic               hold_reg_write_reg, hold_mem_read_reg;
    logic               hold_load;

    logic               in_imm;
    logic [INSTR_W-1:0] cur_word;
    logic [PC_W-1:0]    cur_pc;
    logic [CTRL_W-1:0]  cur_ctrl;
    logic               cur_uses1, cur_uses2, cur_reg_write, cur_mem_read;
    logic [ADDR_W-1:0]  cur_src1, cur_src2;
    logic [DATA_W-1:0]  rd1, rd2;
    logic               have_instr, hazard, issue;
    logic               unused_word_bits;

    // The instruction under decode is the held opcode while waiting for an
    // immediate, otherwise the live fetch word with the decoder's flags.
    assign in_imm        = (state_reg == S_IMM);
    assign cur_word      = in_imm ? hold_instr_reg     : if_instr;
    assign cur_pc        = in_imm ? hold_pc_reg        : if_pc;
    assign cur_ctrl      = in_imm ? hold_ctrl_reg      : dec_ctrl;
    assign cur_uses1     = in_imm ? hold_uses1_reg     : dec_uses_src1;
    assign cur_uses2     = in_imm ? hold_uses2_reg     : dec_uses_src2;
    assign cur_reg_write = in_imm ? hold_reg_write_reg : dec_reg_write;
    assign cur_mem_read  = in_imm ? hold_mem_read_reg  : dec_mem_read;
    assign cur_src1      = cur_word[SRC1_LSB +: ADDR_W];
    assign cur_src2      = cur_word[SRC2_LSB +: ADDR_W];
    assign unused_word_bits = ^cur_word;

    // A load in EX whose destination feeds a used source must not be consumed
    // yet; the held opcode counts as an instruction even without a fetch word.
    assign have_instr = in_imm | if_valid;
    assign hazard = have_instr & ex_reg.valid & ex_reg.mem_read & ex_reg.reg_write &
                    ((cur_uses1 & (cur_src1 == ex_reg.dst)) |
                     (cur_uses2 & (cur_src2 == ex_reg.dst)));
    assign issue  = if_valid & (in_imm | ~dec_needs_imm);

    id_regfile_bypass #(
        .DATA_W (DATA_W),
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (cur_src1),
        .raddr2 (cur_src2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Next-state decision in priority order: flush, downstream stall, hazard, issue.
    always_comb begin
        state_next = state_reg;
        ex_next    = ex_reg;
        hold_load  = 1'b0;
        id_stall   = 1'b0;
        if (flush) begin
            ex_next    = '0;
            state_next = S_DECODE;
        end else if (stall_in) begin
            id_stall = 1'b1;
        end else if (hazard) begin
            id_stall = 1'b1;
            ex_next  = '0;
        end else begin
            ex_next = '0;
            if (!in_imm && if_valid && dec_needs_imm) begin
                hold_load  = 1'b1;
                state_next = S_IMM;
            end else if (issue) begin
                ex_next.valid     = 1'b1;
                ex_next.ctrl      = cur_ctrl;
                ex_next.pc        = cur_pc;
                ex_next.rd1       = rd1;
                ex_next.rd2       = rd2;
                ex_next.imm       = in_imm ? DATA_W'(if_instr) : '0;
                ex_next.src1      = cur_src1;
                ex_next.src2      = cur_src2;
                ex_next.dst       = cur_src1;
                ex_next.shamt     = cur_word[3:0];
                ex_next.reg_write = cur_reg_write;
                ex_next.mem_read  = cur_mem_read;
                state_next        = S_DECODE;
            end
        end
    end

    // FSM and ID/EX register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_DECODE;
            ex_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ex_reg    <= ex_next;
        end
    end

    // Opcode hold registers for two-word instructions; a flush discards them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || (!reset && flush)) begin
            hold_instr_reg     <= '0;
            hold_pc_reg        <= '0;
            hold_ctrl_reg      <= '0;
            hold_uses1_reg     <= 1'b0;
            hold_uses2_reg     <= 1'b0;
            hold_reg_write_reg <= 1'b0;
            hold_mem_read_reg  <= 1'b0;
        end else if (hold_load) begin
            hold_instr_reg     <= if_instr;
            hold_pc_reg        <= if_pc;
            hold_ctrl_reg      <= dec_ctrl;
            hold_uses1_reg     <= dec_uses_src1;
            hold_uses2_reg     <= dec_uses_src2;
            hold_reg_write_reg <= dec_reg_write;
            hold_mem_read_reg  <= dec_mem_read;
        end
    end

    assign ex_valid     = ex_reg.valid;
    assign ex_ctrl      = ex_reg.ctrl;
    assign ex_pc        = ex_reg.pc;
    assign ex_rd1       = ex_reg.rd1;
    assign ex_rd2       = ex_reg.rd2;
    assign ex_imm       = ex_reg.imm;
    assign ex_src1      = ex_reg.src1;
    assign ex_src2      = ex_reg.src2;
    assign ex_dst       = ex_reg.dst;
    assign ex_shamt     = ex_reg.shamt;
    assign ex_reg_write = ex_reg.reg_write;
    assign ex_mem_read  = ex_reg.mem_read;

endmodule
